// File: rtl/dmem_sized.sv
// Byte-addressable data memory with valid/ready request handshake, sized loads/stores and wait states.
// Latency: accept edge E0 -> response registered at edge E0+WAIT_CYCLES+1, rsp_valid high one cycle.
// Backpressure: req_ready low while busy (and during the optional DMEM_INIT_CLEAR_EN clear sweep).
module dmem_sized #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_INIT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        perform;

    logic [3:0]  wait_cnt;

    // Request fields captured at the accept edge; the bus may change afterwards.
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic          acc_fault;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic [31:0]   st_word;
    logic [31:0]   ld_val;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    logic [31:0] mem [DEPTH];

`ifdef DMEM_INIT_CLEAR_EN
    logic [AW-1:0] sweep_idx;
`endif

    assign req_ready = (state == ST_IDLE) && rst_n;

    // State register; reset lands in INIT when the clear sweep is built in, else IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
            state <= ST_INIT;
`else
            state <= ST_IDLE;
`endif
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the accept/perform strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        perform   = 1'b0;
        case (state)
`ifdef DMEM_INIT_CLEAR_EN
            ST_INIT: begin
                if (sweep_idx == {AW{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wait_cnt == 4'd0) begin
                    perform   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fault classification and lane extraction on the captured request.
    always_comb begin
        acc_fault = 1'b0;
        if (lat_size == 2'b11) begin
            acc_fault = 1'b1;
        end
        if ((lat_size == SZ_HALF) && lat_addr[0]) begin
            acc_fault = 1'b1;
        end
        if ((lat_size == SZ_WORD) && (lat_addr[1:0] != 2'b00)) begin
            acc_fault = 1'b1;
        end
        // DEPTH is a power of two, so any set bit above the index field is out of range.
        if (|lat_addr[31:AW+2]) begin
            acc_fault = 1'b1;
        end
    end

    assign word_idx = lat_addr[AW+1:2];
    assign cur_word = mem[word_idx];
    assign ld_byte  = cur_word[{lat_addr[1:0], 3'b000} +: 8];
    assign ld_half  = cur_word[{lat_addr[1], 4'b0000} +: 16];

    // Load value: select lanes and extend per the captured unsigned flag.
    always_comb begin
        ld_val = 32'd0;
        case (lat_size)
            SZ_BYTE: ld_val = lat_unsigned ? {24'd0, ld_byte}
                                           : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = lat_unsigned ? {16'd0, ld_half}
                                           : {{16{ld_half[15]}}, ld_half};
            SZ_WORD: ld_val = cur_word;
            default: ld_val = 32'd0;
        endcase
    end

    // Store merge: replace only the addressed lanes, keep the rest of the word.
    always_comb begin
        st_word = cur_word;
        case (lat_size)
            SZ_BYTE: st_word[{lat_addr[1:0], 3'b000} +: 8]  = lat_wdata[7:0];
            SZ_HALF: st_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            SZ_WORD: st_word = lat_wdata;
            default: st_word = cur_word;
        endcase
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt     <= 4'd0;
            rsp_valid    <= 1'b0;
            rdata        <= 32'd0;
            fault        <= 1'b0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
        end else begin
            rsp_valid <= perform;
            fault     <= perform && acc_fault;
            rdata     <= (perform && !acc_fault && !lat_we) ? ld_val : 32'd0;
            if (accept) begin
                wait_cnt     <= 4'(WAIT_CYCLES);
                lat_we       <= req_we;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= addr;
                lat_wdata    <= wdata;
            end else if ((state == ST_BUSY) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

`ifdef DMEM_INIT_CLEAR_EN
    // Clear-sweep index; restarts from zero on every reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_idx <= '0;
        end else if (state == ST_INIT) begin
            sweep_idx <= sweep_idx + 1'b1;
        end
    end
`endif

    // Memory array: not reset; written by the sweep or by a non-faulting store.
    always_ff @(posedge clk) begin
        if (rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
            if (state == ST_INIT) begin
                mem[sweep_idx] <= 32'd0;
            end
`endif
            if (perform && lat_we && !acc_fault) begin
                mem[word_idx] <= st_word;
            end
        end
    end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised data memory for the RISC CPU datapath. It succeeds the fixed 1024×32 word-only memory. It adds a valid/ready request handshake, byte, halfword and word access with sign or zero extension, byte addressing with alignment and range checks, and a configurable number of wait states. An optional post-reset clear sweep can be compiled in. It sits in the EX/MEM stage; the CPU stalls while `req_ready` is low.

## Interface
- `DEPTH`, 1024: number of 32-bit words; must be a power of 2 and at least 4.
- `WAIT_CYCLES`, 0: extra stall cycles per access; range 0–15.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request; equal to (state==IDLE) && `rst_n`.
- `req_we` input 1: 1 = store, 0 = load (the MW signal).
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_unsigned` input 1: loads zero-extend when 1, sign-extend when 0.
- `addr` input 32: byte address; word index is `addr[log2(DEPTH)+1:2]`.
- `wdata` input 32: store data; the byte and halfword sources are its low bits.
- `rsp_valid` output 1: one-cycle pulse marking access complete.
- `rdata` output 32: extended load result, valid while `rsp_valid`; 0 for stores and faults.
- `fault` output 1: valid while `rsp_valid`; access rejected.

## Operation
- States: INIT (only with the macro), IDLE, BUSY.
- **Accept:**
  - A request is accepted on an edge where `req_valid` && `req_ready`.
  - `req_we`, `req_size`, `req_unsigned`, `addr` and `wdata` are latched at that edge.
  - Inputs may change afterwards without effect.
  - State goes to BUSY and the wait counter loads `WAIT_CYCLES`.
- **BUSY:**
  - On each edge with counter ≠ 0, the counter decrements.
  - On the edge with counter = 0, the access is performed, `rsp_valid`/`rdata`/`fault` are registered, and state returns to IDLE.
- **Fault** is raised when any of these holds:
  - `req_size` = 11.
  - Halfword with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 0.
  - `addr[31:2]` ≥ DEPTH.
- **On fault:** memory is unchanged, `rdata` = 0 and `fault` = 1.
- **Store lanes:**
  - Byte writes lane `addr[1:0]` from `wdata[7:0]`.
  - Halfword writes lanes {`addr[1]`,0} and {`addr[1]`,1} from `wdata[15:0]`.
  - Word writes all lanes.
  - Other bytes of the word are preserved.
- **Load:**
  - Select the same lane(s) as for stores.
  - Extend to 32 bits per `req_unsigned`.
  - Word ignores `req_unsigned`.
- Requests presented while BUSY are ignored; `req_ready` is low.
- A request presented in the cycle `rsp_valid` is high is acceptable, because state is IDLE.
- Memory contents are not affected by reset, except through the INIT sweep.

## Timing
- While `rst_n` is low at an edge, the block resets:
  - `req_ready` = 0, `rsp_valid` = 0, `rdata` = 0, `fault` = 0.
  - Wait counter = 0.
  - State goes to INIT (macro defined) or IDLE (macro not defined).
- **Reset mid-access:** an accepted access whose performing edge has not yet occurred is dropped. No write happens and no response is produced.
- **Latency:** accept edge E0 → perform edge E0+`WAIT_CYCLES`+1. `rsp_valid` is high for exactly the following cycle.
- **Throughput:** one access per `WAIT_CYCLES`+2 cycles.
- `rsp_valid` is deasserted on the edge after it rises, unless a new response completes on that edge, which is impossible since the minimum spacing is 2.
- A load of a word stored by the immediately preceding access returns the new data.

## Configuration
- `DMEM_INIT_CLEAR_EN` defined:
  - After reset the block enters INIT.
  - It writes 0 to word index 0..DEPTH-1, one word per cycle, over DEPTH cycles.
  - `req_ready` stays low throughout, then the block goes to IDLE.
  - Reset asserted during INIT restarts the sweep at index 0.
- `DMEM_INIT_CLEAR_EN` not defined:
  - No INIT state; IDLE follows reset directly.
  - `req_ready` is 1 in the first cycle after `rst_n` is sampled high.
  - Memory contents are only zero via a simulation initial block; hardware contents are undefined.

## Test plan
- **Word store then load:** WAIT_CYCLES=0, store word 0xDEADBEEF at 0x10, then load word at 0x10 → `rsp_valid` pulses 1 cycle after each accept; load `rdata` = 0xDEADBEEF, `fault` = 0.
- **Byte/half lanes and extension:** store word 0x11223344 at 0x20, then byte 0xAB at 0x21 → word reads 0x1122AB44. Load byte at 0x21 signed → 0xFFFFFFAB; unsigned → 0x000000AB. Load half at 0x22 signed → 0x00001122.
- **Faults:** word load at 0x22, half store at 0x23, size 11, and word store at 4·DEPTH → each gives `fault` = 1 and `rdata` = 0; a following load of the affected words shows no change.
- **Wait states:** WAIT_CYCLES=3, accept at edge N → `rsp_valid` high after edge N+4; `req_ready` low for cycles N+1..N+4, high after edge N+4. A second `req_valid` held during BUSY is accepted only at edge N+5.
- **Reset mid-access:** WAIT_CYCLES=3, store 0x55 word at 0x40, `rst_n` low at edge N+2 → no `rsp_valid`; after recovery, the load at 0x40 returns the prior contents (0 with the macro).
- **INIT sweep:** macro defined, DEPTH=16, write garbage to all words, reset → `req_ready` low for 16 cycles; all 16 word loads then return 0. Reset at sweep cycle 8 → 16 further cycles of `req_ready` low.
